// File: rtl/soundrive_pkg.sv
// Shared types and constants for the Soundrive/Covox output path (sequencer states,
// mix widths, reset midpoints and the dither LFSR polynomial).
package soundrive_pkg;

    localparam int MIX_W = 9;

    localparam logic [MIX_W-1:0] MIX_MID   = 9'h100;
    localparam logic [7:0]       SNAP_MID  = 8'h80;
    localparam logic [15:0]      LFSR_SEED = 16'hACE1;
    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
    localparam logic [15:0]      LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SUM_L,
        SUM_R,
        COMMIT
    } state_t;

    function automatic logic [MIX_W-1:0] mix_pair(input logic [7:0] a, input logic [7:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/soundrive_dac_sigma_delta1.sv
// First-order sigma-delta modulator for one audio side; the carry out of the
// 9-bit accumulator is the output bit, with an optional one-LSB dither carry-in.
module sigma_delta1
    import soundrive_pkg::*;
#(
    parameter int ACC_W = MIX_W + 1
) (
    input  logic             clk28,
    input  logic             rst,
    input  logic             en,
    input  logic [MIX_W-1:0] din,
    input  logic             dither,
    output logic             dout
);

    // Only the low ACC_W-1 bits carry state; the top bit of the sum is the output.
    logic [ACC_W-2:0] acc_reg;
    logic [ACC_W-1:0] acc_next;
    logic             dout_reg;

    always_comb begin
        acc_next = {1'b0, acc_reg}
                 + {{(ACC_W-MIX_W){1'b0}}, din}
                 + {{(ACC_W-1){1'b0}}, dither};
    end

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            acc_reg  <= '0;
            dout_reg <= 1'b0;
        end else if (!en) begin
            acc_reg  <= '0;
            dout_reg <= 1'b0;
        end else begin
            acc_reg  <= acc_next[ACC_W-2:0];
            dout_reg <= acc_next[ACC_W-1];
        end
    end

    assign dout = dout_reg;

endmodule

// File: rtl/soundrive_dac.sv
// Soundrive DAC output stage: sample-rate divider, snapshot/mix sequencer and two
// sigma-delta modulators. Define SOUNDRIVE_DAC_DITHER_EN to add LFSR dither.
module soundrive_dac
    import soundrive_pkg::*;
#(
    parameter int SAMPLE_DIV = 256,
    parameter int ACC_W      = MIX_W + 1
) (
    input  logic             clk28,
    input  logic             rst,
    input  logic             en,
    input  logic [7:0]       ch_l0,
    input  logic [7:0]       ch_l1,
    input  logic [7:0]       ch_r0,
    input  logic [7:0]       ch_r1,
    output logic [MIX_W-1:0] mix_l,
    output logic [MIX_W-1:0] mix_r,
    output logic             sample_stb,
    output logic             dac_l,
    output logic             dac_r
);

    localparam int DIV_W = 16;

    logic [DIV_W-1:0] div_cnt_reg;
    logic             tick;

    assign tick = (div_cnt_reg == DIV_W'(SAMPLE_DIV - 1));

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst)       div_cnt_reg <= '0;
        else if (tick) div_cnt_reg <= '0;
        else           div_cnt_reg <= div_cnt_reg + DIV_W'(1);
    end

    state_t state_reg, state_next;
    logic   latch_en, sum_l_en, commit_load;

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next  = state_reg;
        latch_en    = 1'b0;
        sum_l_en    = 1'b0;
        commit_load = 1'b0;
        case (state_reg)
            IDLE:   if (tick) state_next = LATCH;
            LATCH: begin
                latch_en   = 1'b1;
                state_next = SUM_L;
            end
            SUM_L: begin
                sum_l_en   = 1'b1;
                state_next = SUM_R;
            end
            // Mix registers load on the way into COMMIT so they are visible there.
            SUM_R: begin
                commit_load = 1'b1;
                state_next  = COMMIT;
            end
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // All four channels are captured on the same edge so a sample is coherent.
    logic [7:0] ch_in [4];
    logic [7:0] snap  [4];

    assign ch_in = '{ch_l0, ch_l1, ch_r0, ch_r1};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_snap
            logic [7:0] snap_q;
            always_ff @(posedge clk28 or posedge rst) begin
                if (rst)           snap_q <= SNAP_MID;
                else if (latch_en) snap_q <= ch_in[gi];
            end
            assign snap[gi] = snap_q;
        end
    endgenerate

    logic [MIX_W-1:0] sum_l_reg;
    logic [MIX_W-1:0] mix_l_reg, mix_r_reg;
    logic             stb_reg;

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            sum_l_reg <= MIX_MID;
            mix_l_reg <= MIX_MID;
            mix_r_reg <= MIX_MID;
            stb_reg   <= 1'b0;
        end else begin
            stb_reg <= commit_load;
            if (sum_l_en) sum_l_reg <= mix_pair(snap[0], snap[1]);
            if (commit_load) begin
                mix_l_reg <= sum_l_reg;
                mix_r_reg <= mix_pair(snap[2], snap[3]);
            end
        end
    end

    assign mix_l      = mix_l_reg;
    assign mix_r      = mix_r_reg;
    assign sample_stb = stb_reg;

    logic dither_l, dither_r;

`ifdef SOUNDRIVE_DAC_DITHER_EN
    logic [15:0] lfsr_reg;

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst)     lfsr_reg <= LFSR_SEED;
        else if (en) lfsr_reg <= lfsr_step(lfsr_reg);
    end

    assign dither_l = lfsr_reg[0];
    assign dither_r = lfsr_reg[8];
`else
    assign dither_l = 1'b0;
    assign dither_r = 1'b0;
`endif

    sigma_delta1 #(.ACC_W(ACC_W)) u_sd_l (
        .clk28  (clk28),
        .rst    (rst),
        .en     (en),
        .din    (mix_l_reg),
        .dither (dither_l),
        .dout   (dac_l)
    );

    sigma_delta1 #(.ACC_W(ACC_W)) u_sd_r (
        .clk28  (clk28),
        .rst    (rst),
        .en     (en),
        .din    (mix_r_reg),
        .dither (dither_r),
        .dout   (dac_r)
    );

endmodule
